// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU program sequencer.
//   - default datapath widths (address / RAM word / ALU result)
//   - 3-bit FSM state encoding, also exposed on the top-level debug port
package alu_seq_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 20;
  localparam int RES_W_DEF  = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_NEXT  = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

endpackage

// File: rtl/seq_lat_timer.sv
// RAM read-latency timer for the sequencer WAIT state.
//   clk, rst : clock, synchronous active-high reset
//   load     : reload the counter with LAT (asserted during FETCH)
//   dec      : count down by one (asserted during WAIT)
//   expire   : high during the last WAIT cycle (counter about to reach zero)
module seq_lat_timer #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expire
);

  localparam int CW = $clog2(LAT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(LAT);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  // WAIT starts with cnt == LAT, so the cycle holding 1 is the last one;
  // the decrement on that edge takes the counter to zero.
  assign expire = (cnt == CW'(1));

endmodule

// File: rtl/alu_program_sequencer.sv
// Autonomous RAM -> 20-bit word register -> ALU sequencer.
// Walks pc from a start to an end address (inclusive, wrapping), reads one
// RAM word per step, presents it to the ALU and captures the ALU result.
//   clk, rst           : clock, synchronous active-high reset
//   i_start            : pulse, starts a run (ignored while busy)
//   i_step_mode/i_step : pause after each word / advance one word
//   i_abort            : pulse, ends a busy run without setting o_done
//   i_start_addr/i_end_addr : run bounds, latched on accepted i_start
//   o_ram_addr/o_ram_rd/i_ram_data : RAM read port, RAM_LAT cycle latency
//   o_alu_word/i_alu_result        : ALU operand word and its result
//   o_result/o_result_valid        : captured result + one-cycle strobe
//   o_pc/o_count/o_busy/o_done     : status
//   dbg_state                      : current FSM state
// o_result_valid is a plain strobe with no ready: the result is valid in
// exactly the cycle the strobe is high and is held in o_result afterwards.
module alu_program_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int RAM_LAT = 1            // 1..3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_step_mode,
  input  logic              i_step,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [ADDR_W-1:0] i_end_addr,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_rd,
  input  logic [DATA_W-1:0] i_ram_data,
  output logic [DATA_W-1:0] o_alu_word,
  input  logic [RES_W-1:0]  i_alu_result,
  output logic [RES_W-1:0]  o_result,
  output logic              o_result_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W:0]   o_count,
  output logic              o_busy,
  output logic              o_done,
  output state_t            dbg_state
);

  state_t            state, next_state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] end_addr;
  logic              lat_expire;
  logic              abort_now;
  logic              at_end;

  seq_lat_timer #(.LAT(RAM_LAT)) u_lat_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (state == S_FETCH),
    .dec    (state == S_WAIT),
    .expire (lat_expire)
  );

  assign abort_now = i_abort && (state != S_IDLE);
  assign at_end    = (pc == end_addr);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (i_start) next_state = S_FETCH;
      S_FETCH: next_state = S_WAIT;
      S_WAIT:  if (lat_expire) next_state = S_EXEC;
      S_EXEC:  next_state = S_NEXT;
      S_NEXT: begin
        if (at_end)           next_state = S_IDLE;
        else if (i_step_mode) next_state = S_HOLD;
        else                  next_state = S_FETCH;
      end
      S_HOLD:  if (i_step) next_state = S_FETCH;
      default: next_state = S_IDLE;
    endcase
    // Abort overrides every busy transition; in IDLE it has no effect,
    // so a simultaneous start is still accepted.
    if (abort_now) next_state = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= '0;
      end_addr       <= '0;
      o_alu_word     <= '0;
      o_result       <= '0;
      o_result_valid <= 1'b0;
      o_count        <= '0;
      o_done         <= 1'b0;
    end else begin
      o_result_valid <= 1'b0;
      if (state == S_IDLE) begin
        if (i_start) begin
          pc       <= i_start_addr;
          end_addr <= i_end_addr;
          o_count  <= '0;
          o_done   <= 1'b0;
        end
      end else if (!abort_now) begin
        // On abort all datapath registers hold and the in-flight result
        // is dropped, hence this branch is skipped entirely.
        unique case (state)
          S_WAIT: if (lat_expire) o_alu_word <= i_ram_data;
          S_EXEC: begin
            o_result       <= i_alu_result;
            o_result_valid <= 1'b1;
            o_count        <= o_count + (ADDR_W + 1)'(1);
          end
          S_NEXT: begin
            if (at_end) o_done <= 1'b1;
            else        pc     <= pc + ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign o_ram_addr = pc;
  assign o_pc       = pc;
  assign o_ram_rd   = (state == S_FETCH);
  assign o_busy     = (state != S_IDLE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_alu_program_sequencer.sv
// Directed bench for alu_program_sequencer: one instance with RAM latency 1
// for the functional scenarios, one with RAM latency 3 for timing.
module tb_alu_program_sequencer;
  import alu_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared RAM contents ----------------
  logic [19:0] ram [0:1023];

  // ---------------- instance 1 (RAM_LAT = 1) ----------------
  logic        start1 = 0, step_mode1 = 0, step1 = 0, abort1 = 0;
  logic [9:0]  sa1 = '0, ea1 = '0;
  logic [9:0]  addr1;
  logic        rd1;
  logic [19:0] rdata1 = '0;
  logic [19:0] word1;
  logic [7:0]  alu1, res1;
  logic        valid1, busy1, done1;
  logic [9:0]  pc1;
  logic [10:0] count1;
  state_t      st1;

  assign alu1 = word1[7:0];
  always @(posedge clk) if (rd1) rdata1 <= ram[addr1];

  alu_program_sequencer #(.RAM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(start1), .i_step_mode(step_mode1),
    .i_step(step1), .i_abort(abort1), .i_start_addr(sa1), .i_end_addr(ea1),
    .o_ram_addr(addr1), .o_ram_rd(rd1), .i_ram_data(rdata1),
    .o_alu_word(word1), .i_alu_result(alu1), .o_result(res1),
    .o_result_valid(valid1), .o_pc(pc1), .o_count(count1),
    .o_busy(busy1), .o_done(done1), .dbg_state(st1)
  );

  // ---------------- instance 3 (RAM_LAT = 3) ----------------
  logic        start3 = 0, zero3 = 0;
  logic [9:0]  sa3 = '0, ea3 = '0;
  logic [9:0]  addr3;
  logic        rd3;
  logic [19:0] p1 = '0, p2 = '0, p3 = '0;
  logic [19:0] word3;
  logic [7:0]  alu3, res3;
  logic        valid3, busy3, done3;
  logic [9:0]  pc3;
  logic [10:0] count3;
  state_t      st3;

  assign alu3 = word3[7:0];
  always @(posedge clk) begin
    p1 <= ram[addr3];
    p2 <= p1;
    p3 <= p2;
  end

  alu_program_sequencer #(.RAM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .i_start(start3), .i_step_mode(zero3),
    .i_step(zero3), .i_abort(zero3), .i_start_addr(sa3), .i_end_addr(ea3),
    .o_ram_addr(addr3), .o_ram_rd(rd3), .i_ram_data(p3),
    .o_alu_word(word3), .i_alu_result(alu3), .o_result(res3),
    .o_result_valid(valid3), .o_pc(pc3), .o_count(count3),
    .o_busy(busy3), .o_done(done3), .dbg_state(st3)
  );

  // ---------------- monitors (sampled mid-cycle) ----------------
  logic [9:0] rd_q[$];
  int         rd_cyc[$];
  logic [7:0] res_q[$];
  int         res_cyc[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (rd1)    begin rd_q.push_back(addr1); rd_cyc.push_back(cyc); end
    if (valid1) begin res_q.push_back(res1); res_cyc.push_back(cyc); end
  end

  // ---------------- scoreboard counters ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    rd_q.delete(); rd_cyc.delete(); res_q.delete(); res_cyc.delete(); exp_q.delete();
  endtask

  task automatic start_run1(input logic [9:0] s, input logic [9:0] e);
    sa1 = s; ea1 = e; start1 = 1'b1;
    tick();
    start1 = 1'b0;
  endtask

  task automatic wait_state1(input state_t s, input int budget, input string tag);
    int k = 0;
    while (st1 != s && k < budget) begin tick(); k++; end
    check(tag, st1, s);
  endtask

  task automatic wait_idle1(input int budget, input string tag);
    int k = 0;
    while (busy1 && k < budget) begin tick(); k++; end
    check(tag, busy1, 1'b0);
  endtask

  task automatic check_results(input string tag);
    check({tag, "_nres"}, res_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_res%0d", tag, i), (i < res_q.size()) ? res_q[i] : 8'hxx, exp_q[i]);
  endtask

  // ---------------- stimulus ----------------
  int d;
  int rd_before;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 20'hA0000 | 20'(i);
    ram[5] = 20'h00011; ram[6] = 20'h00022; ram[7] = 20'h00033;
    ram[4] = 20'h5A5A5;

    // Reset state
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    check("rst_state", st1, S_IDLE);
    check("rst_pc", pc1, 0);
    check("rst_rd", rd1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_count", count1, 0);
    check("rst_word3", word3, 0);

    // Free run 5..7
    clear_logs();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    start_run1(10'd5, 10'd7);
    check("fr_busy", busy1, 1);
    wait_idle1(60, "fr_finish");
    check("fr_nrd", rd_q.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("fr_addr%0d", i), (i < rd_q.size()) ? rd_q[i] : 10'hxxx, 5 + i);
    check_results("fr");
    d = (res_cyc.size() >= 2) ? res_cyc[1] - res_cyc[0] : -1;
    check("fr_gap01", d, 4);
    d = (res_cyc.size() >= 3) ? res_cyc[2] - res_cyc[1] : -1;
    check("fr_gap12", d, 4);
    d = (res_cyc.size() >= 1 && rd_cyc.size() >= 1) ? res_cyc[0] - rd_cyc[0] : -1;
    check("fr_first_lat", d, 3);
    check("fr_count", count1, 3);
    check("fr_done", done1, 1);
    check("fr_pc", pc1, 7);

    // Wrap 1022..1
    clear_logs();
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    start_run1(10'd1022, 10'd1);
    check("wr_done_clr", done1, 0);
    wait_idle1(80, "wr_finish");
    check("wr_nrd", rd_q.size(), 4);
    check("wr_addr0", (rd_q.size() > 0) ? rd_q[0] : 10'hxxx, 1022);
    check("wr_addr1", (rd_q.size() > 1) ? rd_q[1] : 10'hxxx, 1023);
    check("wr_addr2", (rd_q.size() > 2) ? rd_q[2] : 10'hxxx, 0);
    check("wr_addr3", (rd_q.size() > 3) ? rd_q[3] : 10'hxxx, 1);
    check_results("wr");
    check("wr_count", count1, 4);
    check("wr_done", done1, 1);

    // Step mode 10..12
    clear_logs();
    step_mode1 = 1'b1;
    start_run1(10'd10, 10'd12);
    wait_state1(S_HOLD, 20, "st_hold1");
    check("st_nres1", res_q.size(), 1);
    check("st_res1", res1, 8'h0A);
    ticks(50);
    check("st_still_hold", st1, S_HOLD);
    check("st_nrd_hold", rd_q.size(), 1);
    step1 = 1'b1; tick(); step1 = 1'b0;
    check("st_fetch", st1, S_FETCH);
    wait_state1(S_EXEC, 10, "st_exec");
    step1 = 1'b1; tick(); step1 = 1'b0;      // step during EXEC: ignored
    wait_state1(S_HOLD, 10, "st_hold2");
    ticks(5);
    check("st_hold2_stays", st1, S_HOLD);
    check("st_nres2", res_q.size(), 2);
    check("st_res2", res1, 8'h0B);
    check("st_done_mid", done1, 0);
    step1 = 1'b1; tick(); step1 = 1'b0;
    wait_idle1(20, "st_finish");
    check("st_nres3", res_q.size(), 3);
    check("st_res3", res1, 8'h0C);
    check("st_done", done1, 1);
    check("st_count", count1, 3);
    check("st_pc", pc1, 12);
    step_mode1 = 1'b0;

    // Second start ignored while busy, then abort in WAIT
    clear_logs();
    start_run1(10'd100, 10'd110);
    tick();
    check("ab_in_wait", st1, S_WAIT);
    sa1 = 10'd200; ea1 = 10'd300; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("ab_pc_kept", pc1, 100);
    check("ab_exec", st1, S_EXEC);
    wait_state1(S_WAIT, 10, "ab_wait2");
    check("ab_pc_pre", pc1, 101);
    abort1 = 1'b1; tick(); abort1 = 1'b0;
    check("ab_idle", st1, S_IDLE);
    check("ab_rd", rd1, 0);
    check("ab_done", done1, 0);
    check("ab_result_held", res1, 8'h64);
    check("ab_pc", pc1, 101);
    check("ab_count", count1, 1);
    ticks(5);
    check("ab_nres", res_q.size(), 1);
    check("ab_nrd", rd_q.size(), 2);

    // Start and abort together in IDLE: start wins
    sa1 = 10'd20; ea1 = 10'd20; start1 = 1'b1; abort1 = 1'b1;
    tick();
    start1 = 1'b0; abort1 = 1'b0;
    check("sa_fetch", st1, S_FETCH);
    wait_idle1(20, "sa_finish");
    check("sa_done", done1, 1);
    check("sa_result", res1, 8'h14);

    // Reset mid-EXEC
    start_run1(10'd30, 10'd40);
    wait_state1(S_EXEC, 10, "rr_exec");
    rst = 1'b1; tick(); rst = 1'b0;
    rd_before = rd_q.size();
    check("rr_state", st1, S_IDLE);
    check("rr_pc", pc1, 0);
    check("rr_addr", addr1, 0);
    check("rr_word", word1, 0);
    check("rr_result", res1, 0);
    check("rr_valid", valid1, 0);
    check("rr_count", count1, 0);
    check("rr_busy", busy1, 0);
    check("rr_done", done1, 0);
    ticks(10);
    check("rr_no_rd", rd_q.size(), rd_before);

    // RAM latency 3, single word at 4
    sa3 = 10'd4; ea3 = 10'd4; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    check("l3_fetch_rd", rd3, 1);
    check("l3_fetch_addr", addr3, 4);
    ticks(3);
    check("l3_wait3", st3, S_WAIT);
    check("l3_word_not_yet", word3, 0);
    check("l3_rd_wait", rd3, 0);
    tick();
    check("l3_word", word3, 20'h5A5A5);
    check("l3_exec", st3, S_EXEC);
    check("l3_novalid_exec", valid3, 0);
    tick();
    check("l3_valid", valid3, 1);
    check("l3_result", res3, 8'hA5);
    check("l3_count", count3, 1);
    tick();
    check("l3_valid_off", valid3, 0);
    check("l3_idle", st3, S_IDLE);
    check("l3_done", done3, 1);
    check("l3_pc", pc3, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
